// File: rtl/axis_router_pkg.sv
// rtl/axis_router_pkg.sv - shared state/route types and select decode for the 1:2 packet router
package axis_router_pkg;

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B, DROP} state_e;
    typedef enum logic [1:0] {RT_A, RT_B, RT_DROP} route_e;

    // A non-one-hot select either falls back to output A or discards the packet.
    function automatic route_e decode_route(input logic sel_a, input logic sel_b, input logic drop_en);
        if (sel_a != sel_b) begin
            return sel_b ? RT_B : RT_A;
        end
        return drop_en ? RT_DROP : RT_A;
    endfunction

endpackage

// File: rtl/axis_rt_skid.sv
// rtl/axis_rt_skid.sv - 2-entry skid buffer with registered output and registered s_tready
module axis_rt_skid #(
    parameter int W = 33
) (
    input  logic         axis_aclk,
    input  logic         axis_aresetn,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    output logic         s_tready,
    output logic         m_tvalid,
    output logic [W-1:0] m_tdata,
    input  logic         m_tready
);

    logic         sk_valid;
    logic [W-1:0] sk_data;

    // Ready depends only on the spare entry, so m_tready never reaches s_tready combinationally.
    assign s_tready = !sk_valid;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
        end else if (m_tready || !m_tvalid) begin
            if (sk_valid) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sk_data;
                sk_valid <= 1'b0;
            end else begin
                m_tvalid <= s_tvalid;
                if (s_tvalid) begin
                    m_tdata <= s_tdata;
                end
            end
        end else if (s_tvalid && !sk_valid) begin
            sk_valid <= 1'b1;
            sk_data  <= s_tdata;
        end
    end

endmodule

// File: rtl/axis_router.sv
// rtl/axis_router.sv - 1:2 AXI-Stream packet router; AXIS_ROUTER_DROP_EN discards packets with a=b
module axis_router
    import axis_router_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    input  logic [DATA_W-1:0] s0k_axis_tdata,
    input  logic              s0k_axis_tvalid,
    output logic              s0k_axis_tready,
    input  logic              s0k_axis_tlast,
    input  logic              s0k_axis_a,
    input  logic              s0k_axis_b,
    output logic [DATA_W-1:0] m0a_axis_tdata,
    output logic              m0a_axis_tvalid,
    input  logic              m0a_axis_tready,
    output logic              m0a_axis_tlast,
    output logic [DATA_W-1:0] m0b_axis_tdata,
    output logic              m0b_axis_tvalid,
    input  logic              m0b_axis_tready,
    output logic              m0b_axis_tlast,
`ifdef AXIS_ROUTER_DROP_EN
    output logic [CNT_W-1:0]  drop_cnt,
`endif
    output logic              router_busy
);

`ifdef AXIS_ROUTER_DROP_EN
    localparam logic DropEn = 1'b1;
`else
    localparam logic DropEn = 1'b0;
`endif

    state_e            state;
    route_e            route;
    logic              route_ready;
    logic              accept;
    logic              push_a;
    logic              push_b;
    logic              a_in_ready;
    logic              b_in_ready;
    logic [DATA_W:0]   a_out;
    logic [DATA_W:0]   b_out;

    always_comb begin
        route = RT_A;
        case (state)
            IDLE:    route = decode_route(s0k_axis_a, s0k_axis_b, DropEn);
            LOCK_A:  route = RT_A;
            LOCK_B:  route = RT_B;
            default: route = RT_DROP;
        endcase
    end

    always_comb begin
        route_ready = 1'b1;
        case (route)
            RT_A:    route_ready = a_in_ready;
            RT_B:    route_ready = b_in_ready;
            default: route_ready = 1'b1;
        endcase
    end

    assign s0k_axis_tready = axis_aresetn & route_ready;
    assign accept          = s0k_axis_tvalid & s0k_axis_tready;
    assign push_a          = accept & (route == RT_A);
    assign push_b          = accept & (route == RT_B);
    assign router_busy     = (state != IDLE);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state <= IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!s0k_axis_tlast) begin
                        case (route)
                            RT_A:    state <= LOCK_A;
                            RT_B:    state <= LOCK_B;
                            default: state <= DROP;
                        endcase
                    end
                end
                default: begin
                    if (s0k_axis_tlast) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef AXIS_ROUTER_DROP_EN
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            drop_cnt <= '0;
        end else if (accept && state == IDLE && route == RT_DROP && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

    axis_rt_skid #(.W(DATA_W + 1)) u_skid_a (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .s_tvalid     (push_a),
        .s_tdata      ({s0k_axis_tlast, s0k_axis_tdata}),
        .s_tready     (a_in_ready),
        .m_tvalid     (m0a_axis_tvalid),
        .m_tdata      (a_out),
        .m_tready     (m0a_axis_tready)
    );

    axis_rt_skid #(.W(DATA_W + 1)) u_skid_b (
        .axis_aclk    (axis_aclk),
        .axis_aresetn (axis_aresetn),
        .s_tvalid     (push_b),
        .s_tdata      ({s0k_axis_tlast, s0k_axis_tdata}),
        .s_tready     (b_in_ready),
        .m_tvalid     (m0b_axis_tvalid),
        .m_tdata      (b_out),
        .m_tready     (m0b_axis_tready)
    );

    assign m0a_axis_tlast = a_out[DATA_W];
    assign m0a_axis_tdata = a_out[DATA_W-1:0];
    assign m0b_axis_tlast = b_out[DATA_W];
    assign m0b_axis_tdata = b_out[DATA_W-1:0];

endmodule
